// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register that feeds operands, PC, destination and the
//   5-bit ALU opcode into the EX-stage ALU of the RV32IM pipeline.
//   A div-class op (div/divu/rem/remu) is held in EX for DIV_HOLD cycles,
//   because the ALU's combinational divider is a multicycle path. ex_busy
//   tells upstream to stall during that hold.
//
//   Optional build macro: LOAD_USE_DETECT_EN
//     defined   -> ex_load_use flags a load in EX whose rd feeds the ID op
//     undefined -> ex_load_use is tied to 0
//
// Ports
//   CLK, RESET                  clock, asynchronous active-high reset
//   STALL_IN                    hazard stall: EX receives a bubble
//   FLUSH_IN                    pipeline flush, clears EX (aborts a divide)
//   id_valid, id_alu_op         ID instruction valid and ALU opcode
//   id_data1, id_data2, id_pc   operands and PC
//   id_rd, id_rs1, id_rs2       register addresses
//   id_use_rs1, id_use_rs2      ID instruction reads rs1/rs2
//   id_reg_write/mem_read/mem_write  control bits
//   ex_*                        registered EX-stage copies
//   ex_busy                     multicycle op occupies EX
//   ex_advance                  EX result final this cycle
//   ex_load_use                 load-use hazard flag
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int DIV_HOLD = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               STALL_IN,
  input  logic               FLUSH_IN,
  input  logic               id_valid,
  input  logic [4:0]         id_alu_op,
  input  logic [DATA_W-1:0]  id_data1,
  input  logic [DATA_W-1:0]  id_data2,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  output logic               ex_valid,
  output logic [4:0]         ex_alu_op,
  output logic [DATA_W-1:0]  ex_data1,
  output logic [DATA_W-1:0]  ex_data2,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_busy,
  output logic               ex_advance,
  output logic               ex_load_use
);

  // Counter only needs to hold DIV_HOLD-1.
  localparam int CNT_W = (DIV_HOLD > 1) ? $clog2(DIV_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(DIV_HOLD - 1);
  localparam bit HOLD_EN = (DIV_HOLD > 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic               r_valid;
  logic [4:0]         r_alu_op;
  logic [DATA_W-1:0]  r_data1;
  logic [DATA_W-1:0]  r_data2;
  logic [DATA_W-1:0]  r_pc;
  logic [RADDR_W-1:0] r_rd;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;

  logic               w_busy;
  logic               w_id_div;

  // div/divu/rem/remu occupy opcodes 01000..01011.
  assign w_id_div = (id_alu_op[4:2] == 3'b010);
  assign w_busy   = (r_state == HOLD);

  // ---- hold FSM: state register ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- hold FSM: next state (flush > busy > stall > load) ----
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (FLUSH_IN) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_busy) begin
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
    end else if (STALL_IN) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (id_valid && w_id_div && HOLD_EN) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = HOLD_INIT;
    end
  end

  // ---- ID -> EX register ----
  // A stall keeps operands/opcode/rd and only kills valid and control, so a
  // bubble never looks like a real instruction downstream.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid     <= 1'b0;
      r_alu_op    <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (FLUSH_IN) begin
      r_valid     <= 1'b0;
      r_alu_op    <= '0;
      r_data1     <= '0;
      r_data2     <= '0;
      r_pc        <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!w_busy) begin
      if (STALL_IN) begin
        r_valid     <= 1'b0;
        r_reg_write <= 1'b0;
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end else begin
        r_valid     <= id_valid;
        r_alu_op    <= id_alu_op;
        r_data1     <= id_data1;
        r_data2     <= id_data2;
        r_pc        <= id_pc;
        r_rd        <= id_rd;
        r_reg_write <= id_reg_write & id_valid;
        r_mem_read  <= id_mem_read  & id_valid;
        r_mem_write <= id_mem_write & id_valid;
      end
    end
  end

  // ---- EX outputs ----
  assign ex_valid     = r_valid;
  assign ex_alu_op    = r_alu_op;
  assign ex_data1     = r_data1;
  assign ex_data2     = r_data2;
  assign ex_pc        = r_pc;
  assign ex_rd        = r_rd;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_busy      = w_busy;
  assign ex_advance   = r_valid & ~w_busy;

`ifdef LOAD_USE_DETECT_EN
  // x0 is never a real dependency, so rd==0 never raises the hazard.
  assign ex_load_use = r_valid & r_mem_read & (r_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == r_rd)) |
                        (id_use_rs2 & (id_rs2 == r_rd)));
`else
  logic w_unused_lu;
  assign w_unused_lu = ^{id_rs1, id_rs2, id_use_rs1, id_use_rs2};
  assign ex_load_use = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

`ifdef LOAD_USE_DETECT_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STALL_IN, FLUSH_IN;
  logic        id_valid;
  logic [4:0]  id_alu_op;
  logic [31:0] id_data1, id_data2, id_pc;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic [31:0] ex_data1, ex_data2, ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_busy, ex_advance, ex_load_use;

  id_ex_stage_reg #(.DATA_W(32), .RADDR_W(5), .DIV_HOLD(4)) dut (
    .CLK(CLK), .RESET(RESET), .STALL_IN(STALL_IN), .FLUSH_IN(FLUSH_IN),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_data1(id_data1), .id_data2(id_data2), .id_pc(id_pc),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_busy(ex_busy),
    .ex_advance(ex_advance), .ex_load_use(ex_load_use)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall, flush, valid;
    logic [4:0]  op;
    logic [31:0] d1, d2, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } in_t;

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [31:0] d1, d2, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, busy, adv, lu;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t tbl[23];

  function automatic in_t mi(logic s, logic f, logic v, logic [4:0] op,
                             logic [31:0] d1, logic [31:0] d2, logic [31:0] pc,
                             logic [4:0] rd, logic rw, logic mr, logic mw);
    in_t r;
    r.stall = s; r.flush = f; r.valid = v; r.op = op;
    r.d1 = d1; r.d2 = d2; r.pc = pc; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mw = mw;
    return r;
  endfunction

  function automatic exp_t me(logic v, logic [4:0] op, logic [31:0] d1,
                              logic [31:0] d2, logic [31:0] pc, logic [4:0] rd,
                              logic rw, logic mr, logic mw, logic busy,
                              logic adv);
    exp_t r;
    r.valid = v; r.op = op; r.d1 = d1; r.d2 = d2; r.pc = pc; r.rd = rd;
    r.rw = rw; r.mr = mr; r.mw = mw; r.busy = busy; r.adv = adv;
    r.lu = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(e.valid));
    chk({tag, ".op"},    32'(ex_alu_op), 32'(e.op));
    chk({tag, ".d1"},    ex_data1, e.d1);
    chk({tag, ".d2"},    ex_data2, e.d2);
    chk({tag, ".pc"},    ex_pc, e.pc);
    chk({tag, ".rd"},    32'(ex_rd), 32'(e.rd));
    chk({tag, ".rw"},    32'(ex_reg_write), 32'(e.rw));
    chk({tag, ".mr"},    32'(ex_mem_read), 32'(e.mr));
    chk({tag, ".mw"},    32'(ex_mem_write), 32'(e.mw));
    chk({tag, ".busy"},  32'(ex_busy), 32'(e.busy));
    chk({tag, ".adv"},   32'(ex_advance), 32'(e.adv));
    chk({tag, ".lu"},    32'(ex_load_use), 32'(e.lu));
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after edge.
  task automatic step(input string tag, input in_t i, input exp_t e);
    exp_t got;
    @(negedge CLK);
    STALL_IN = i.stall; FLUSH_IN = i.flush; id_valid = i.valid;
    id_alu_op = i.op; id_data1 = i.d1; id_data2 = i.d2; id_pc = i.pc;
    id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr;
    id_mem_write = i.mw;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      got = sb_q.pop_front();
      cmp(tag, got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z, e;
    in_t  nop;
    z   = me(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop = mi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            stall flush valid op     d1      d2    pc     rd  rw mr mw
    tbl[0]  = '{mi(0,0,1,5'd0, 5,    3,  32'h100, 4, 1,0,0), me(1,5'd0, 5,  3, 32'h100, 4, 1,0,0, 0,1)};
    tbl[1]  = '{mi(1,0,1,5'd0, 9,    9,  32'h104, 6, 1,0,0), me(0,5'd0, 5,  3, 32'h100, 4, 0,0,0, 0,0)};
    tbl[2]  = '{mi(0,0,0,5'd3, 11,   12, 32'h108, 7, 1,1,1), me(0,5'd3, 11, 12,32'h108, 7, 0,0,0, 0,0)};
    tbl[3]  = '{mi(0,0,1,5'd0, 32'h80,4, 32'h10c, 5, 1,1,0), me(1,5'd0, 32'h80,4,32'h10c,5, 1,1,0, 0,1)};
    tbl[4]  = '{mi(0,0,1,5'd0, 1,    2,  32'h110, 0, 0,0,1), me(1,5'd0, 1,  2, 32'h110, 0, 0,0,1, 0,1)};
    tbl[5]  = '{mi(0,0,1,5'd9, 100,  7,  32'h114, 8, 1,0,0), me(1,5'd9, 100,7, 32'h114, 8, 1,0,0, 1,0)};
    tbl[6]  = '{mi(1,0,1,5'd0, 1,    1,  32'h118, 9, 1,0,0), me(1,5'd9, 100,7, 32'h114, 8, 1,0,0, 1,0)};
    tbl[7]  = '{mi(0,0,1,5'd0, 1,    1,  32'h118, 9, 1,0,0), me(1,5'd9, 100,7, 32'h114, 8, 1,0,0, 1,0)};
    tbl[8]  = '{mi(0,0,1,5'd0, 1,    1,  32'h118, 9, 1,0,0), me(1,5'd9, 100,7, 32'h114, 8, 1,0,0, 0,1)};
    tbl[9]  = '{mi(0,0,1,5'd0, 1,    1,  32'h118, 9, 1,0,0), me(1,5'd0, 1,  1, 32'h118, 9, 1,0,0, 0,1)};
    tbl[10] = '{mi(0,0,1,5'd10,50,   6,  32'h11c, 10,1,0,0), me(1,5'd10,50, 6, 32'h11c, 10,1,0,0, 1,0)};
    tbl[11] = '{mi(0,0,1,5'd10,50,   6,  32'h11c, 10,1,0,0), me(1,5'd10,50, 6, 32'h11c, 10,1,0,0, 1,0)};
    tbl[12] = '{mi(0,1,1,5'd10,50,   6,  32'h11c, 10,1,0,0), me(0,5'd0, 0,  0, 0,       0, 0,0,0, 0,0)};
    tbl[13] = '{mi(0,0,1,5'd0, 2,    3,  32'h120, 11,1,0,0), me(1,5'd0, 2,  3, 32'h120, 11,1,0,0, 0,1)};
    tbl[14] = '{mi(0,0,1,5'd8, 20,   4,  32'h124, 12,1,0,0), me(1,5'd8, 20, 4, 32'h124, 12,1,0,0, 1,0)};
    tbl[15] = '{mi(0,0,1,5'd11,30,   5,  32'h128, 13,1,0,0), me(1,5'd8, 20, 4, 32'h124, 12,1,0,0, 1,0)};
    tbl[16] = '{mi(0,0,1,5'd11,30,   5,  32'h128, 13,1,0,0), me(1,5'd8, 20, 4, 32'h124, 12,1,0,0, 1,0)};
    tbl[17] = '{mi(0,0,1,5'd11,30,   5,  32'h128, 13,1,0,0), me(1,5'd8, 20, 4, 32'h124, 12,1,0,0, 0,1)};
    tbl[18] = '{mi(0,0,1,5'd11,30,   5,  32'h128, 13,1,0,0), me(1,5'd11,30, 5, 32'h128, 13,1,0,0, 1,0)};
    tbl[19] = '{mi(0,0,1,5'd0, 7,    7,  32'h12c, 14,1,0,0), me(1,5'd11,30, 5, 32'h128, 13,1,0,0, 1,0)};
    tbl[20] = '{mi(0,0,1,5'd0, 7,    7,  32'h12c, 14,1,0,0), me(1,5'd11,30, 5, 32'h128, 13,1,0,0, 1,0)};
    tbl[21] = '{mi(0,0,1,5'd0, 7,    7,  32'h12c, 14,1,0,0), me(1,5'd11,30, 5, 32'h128, 13,1,0,0, 0,1)};
    tbl[22] = '{mi(1,1,1,5'd0, 7,    7,  32'h12c, 14,1,1,1), me(0,5'd0, 0,  0, 0,       0, 0,0,0, 0,0)};

    RESET = 1'b1; STALL_IN = 0; FLUSH_IN = 0; id_valid = 0; id_alu_op = 0;
    id_data1 = 0; id_data2 = 0; id_pc = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0;
    repeat (2) @(posedge CLK);
    #1;
    cmp("reset", z);
    @(negedge CLK);
    RESET = 1'b0;

    for (int k = 0; k < 23; k++)
      step($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);

    // Reset asserted in the second cycle of a div hold.
    step("rst_div_load", mi(0,0,1,5'd8,100,7,32'h200,3,1,0,0),
         me(1,5'd8,100,7,32'h200,3,1,0,0,1,0));
    step("rst_div_hold2", nop, me(1,5'd8,100,7,32'h200,3,1,0,0,1,0));
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    cmp("rst_mid_hold", z);
    @(negedge CLK);
    RESET = 1'b0;
    step("post_rst_add", mi(0,0,1,5'd0,6,2,32'h204,2,1,0,0),
         me(1,5'd0,6,2,32'h204,2,1,0,0,0,1));

    // Load-use: load to rd=5 in EX, ID reads rs2=5.
    step("lu_load", mi(0,0,1,5'd0,32'h40,0,32'h208,5,1,1,0),
         me(1,5'd0,32'h40,0,32'h208,5,1,1,0,0,1));
    id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    chk("lu_rs2_hit", 32'(ex_load_use), 32'(LU_EN));
    id_use_rs2 = 1'b0;
    #1;
    chk("lu_rs2_unused", 32'(ex_load_use), 32'(0));
    id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    chk("lu_rs1_hit", 32'(ex_load_use), 32'(LU_EN));
    id_rs1 = 5'd0; id_use_rs1 = 1'b0; id_rs2 = 5'd0;
    step("lu_load_x0", mi(0,0,1,5'd0,32'h44,0,32'h20c,0,1,1,0),
         me(1,5'd0,32'h44,0,32'h20c,0,1,1,0,0,1));
    id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    #1;
    chk("lu_rd_zero", 32'(ex_load_use), 32'(0));
    id_use_rs2 = 1'b0;

    e = z;
    step("final_flush", mi(0,1,1,5'd0,1,1,32'h210,1,1,0,0), e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
